// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider with glitch-free start/stop,
// boundary-aligned divisor updates and a startup-gated pad output enable.
`timescale 1ns/1ps

module clock_div_multi #(
   parameter int CHANNELS    = 2,
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 4,
   parameter int STARTUP     = 16
) (
   input  logic                clk_in,
   input  logic                reset,
   input  logic                cfg_wr,
   input  logic [2:0]          cfg_ch,
   input  logic [DIV_W-1:0]    cfg_div,
   input  logic [CHANNELS-1:0] ch_en,
   output logic [CHANNELS-1:0] clk_out,
   output logic                clk_oe,
   output logic [CHANNELS-1:0] cfg_pending,
   output logic                locked
);

   localparam int SW = $clog2(STARTUP + 1);

   typedef enum logic {
      CH_PARKED,
      CH_RUNNING
   } ch_state_t;

   logic [1:0]    rst_sync;
   logic [SW-1:0] start_cnt;

   // Reset asserts immediately but only releases two clk_in edges later.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         start_cnt <= '0;
         locked    <= 1'b0;
      end else if (rst_sync[1] && !locked) begin
         if (start_cnt == SW'(STARTUP)) begin
            locked <= 1'b1;
         end else begin
            start_cnt <= start_cnt + SW'(1);
         end
      end
   end

   assign clk_oe = locked;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      ch_state_t        state;
      logic [DIV_W-1:0] active_div;
      logic [DIV_W-1:0] pend_div;
      logic [DIV_W-1:0] phase;
      logic             clk_q;
      logic             pend_q;
      logic [DIV_W-1:0] eff_div;
      logic [DIV_W:0]   half;
      logic [DIV_W:0]   phase_nxt;
      logic             at_boundary;
      logic             wr_hit;
      logic             go;

      // Divisors 0 and 1 cannot make a two-phase clock, so they run as 2.
      assign eff_div     = (active_div < DIV_W'(2)) ? DIV_W'(2) : active_div;
      assign half        = ({1'b0, eff_div} + (DIV_W+1)'(1)) >> 1;
      assign phase_nxt   = {1'b0, phase} + (DIV_W+1)'(1);
      assign at_boundary = (state == CH_PARKED) || (phase == eff_div - DIV_W'(1));
      assign wr_hit      = cfg_wr && (cfg_ch == 3'(g));
      assign go          = locked && ch_en[g];

      // Divisor swaps and start/stop decisions only happen at a period
      // boundary, so neither phase of the output can ever be shortened.
      always_ff @(posedge clk_in or negedge reset) begin
         if (!reset) begin
            state      <= CH_PARKED;
            phase      <= '0;
            clk_q      <= 1'b0;
            active_div <= DIV_W'(DIV_DEFAULT);
            pend_div   <= DIV_W'(DIV_DEFAULT);
            pend_q     <= 1'b0;
         end else begin
            if (at_boundary && pend_q) begin
               active_div <= pend_div;
            end
            if (wr_hit) begin
               pend_div <= cfg_div;
               pend_q   <= 1'b1;
            end else if (at_boundary) begin
               pend_q <= 1'b0;
            end
            if (at_boundary) begin
               phase <= '0;
               if (go) begin
                  state <= CH_RUNNING;
                  clk_q <= 1'b1;
               end else begin
                  state <= CH_PARKED;
                  clk_q <= 1'b0;
               end
            end else begin
               phase <= phase + DIV_W'(1);
               clk_q <= (phase_nxt < half);
            end
         end
      end

      assign clk_out[g]     = clk_q;
      assign cfg_pending[g] = pend_q;
   end

endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Parametrised multi-channel successor to the single-output CPLD clock block.
- Derives CHANNELS independent clocks from clk_in (CPU, bus, peripheral).
- Each channel has a runtime-programmable divisor, a glitch-free enable/stop and glitch-free divisor changes.
- A common output-enable (clk_oe) drives external tristate buffers and is held off until a post-reset startup delay expires.

Parameters:
- CHANNELS, 2, number of divided clock outputs (1..8).
- DIV_W, 8, divisor register width.
- DIV_DEFAULT, 4, divisor loaded into every channel at reset (>=2).
- STARTUP, 16, clk_in cycles from synchronised reset release to clk_oe assertion (>=1).

Ports:
- clk_in  in  1  master clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_wr  in  1  one-cycle write strobe for a divisor update.
- cfg_ch  in  3  target channel index for cfg_wr.
- cfg_div  in  DIV_W  new divisor value.
- ch_en  in  CHANNELS  per-channel run enable (level).
- clk_out  out  CHANNELS  divided clocks, registered.
- clk_oe  out  1  tristate enable for the clk_out pads.
- cfg_pending  out  CHANNELS  a divisor change is queued and not yet applied.
- locked  out  1  startup complete; equals clk_oe.

Behaviour:
- Reset asserted (async):
  - clk_out=0, clk_oe=0, locked=0, cfg_pending=0.
  - Startup counter=0, per-channel phase counters=0.
  - Active and pending divisors=DIV_DEFAULT.
- Reset release:
  - Assertion is async; deassertion passes a 2-flop synchroniser on clk_in.
  - Internal release is seen at rising edge R+2, where R is the first edge with reset high.
- Startup:
  - Counter increments each edge after internal release.
  - clk_oe/locked rise at edge E = R+2+STARTUP and stay high until the next reset.
  - cfg_wr is accepted during startup.
- Divisor rules:
  - Effective divisor D = max(active_div, 2); values 0 and 1 behave as 2.
  - Period = D clk_in cycles: high ceil(D/2) cycles, then low floor(D/2) cycles.
  - Phase counter runs 0..D-1 and wraps.
  - clk_out is high while the counter is < ceil(D/2).
- Channel start:
  - A channel with ch_en high at E starts counting at E.
  - Its clk_out first rises at edge E+1.
  - Channels enabled at E are phase-aligned.
- Channel stop (ch_en falls):
  - The channel completes its current period and parks with the counter at 0 and clk_out=0.
  - Never a shortened high or low phase.
- Channel restart (ch_en rises while parked):
  - clk_out rises on the next edge.
  - ch_en toggling mid-period has no effect until the period boundary.
- Divisor update:
  - cfg_wr with cfg_ch < CHANNELS loads the pending divisor and sets cfg_pending[ch] on the next edge.
  - cfg_ch >= CHANNELS: write ignored.
- Boundary (counter == D-1, or parked):
  - If pending is set, active <= pending and cfg_pending clears.
  - The next period uses the new D; no runt pulse.
- Simultaneous events:
  - Write on the same edge as a boundary: any previously queued value is applied at this boundary.
  - The new value becomes pending and applies at the following boundary.
  - Two writes to the same channel before a boundary: last write wins.
- Edge cases:
  - Divisor change with ch_en low: applied immediately, since the channel is parked at a boundary.
  - Reset mid-operation: all outputs drop asynchronously to reset values; the startup sequence repeats in full.
- Widths:
  - Phase counter is DIV_W bits; D up to 2^DIV_W-1.
  - ceil(D/2) computed as (D+1)>>1 in DIV_W+1 bits.

Test Plan:
- Reset held 100 ns then released, STARTUP=16, DIV_DEFAULT=4, ch_en=all 1 -> clk_oe rises exactly 18 edges after release; both clk_out rise at the next edge and toggle 2 high/2 low, phase-aligned.
- Write ch0 div=6 mid-period -> cfg_pending[0]=1 until the current 4-cycle period ends; next period is 3 high/3 low; no pulse shorter than 2 cycles; ch1 unaffected.
- Write div=5, then div=1 before the boundary -> the 1 wins and is treated as 2: 1 high/1 low; write div=7 -> 4 high/3 low.
- Drop ch_en[1] one cycle into its high phase -> the high phase and the following low phase complete in full, then clk_out[1] stays 0; raise ch_en[1] -> rises on the next edge.
- Write with cfg_ch=5 (CHANNELS=2) -> no cfg_pending change, no period change; write on the exact boundary edge -> applied one period later.
- Assert reset mid-high-phase -> clk_out, clk_oe and locked go 0 without waiting for a clk_in edge; after release the full 2+STARTUP delay repeats and the divisor returns to DIV_DEFAULT.
